// File: rtl/db15_joy_responder.sv
// Purpose : device side of the DB15 serial joystick link; acts like two chained 74HC165s.
//           On LOAD it snapshots two player words, then shifts them out on JOY_DATA, one bit per host JOY_CLK.
// Latency : joy_data follows a load or a shift SYNC_STAGES+2 clk cycles after the host input edge.
// Backpr. : none; the host paces the link and must hold each joy_clk half-period for SYNC_STAGES+3 clk or more.
//
// Ports:
//   clk, reset             system clock (40-50 MHz), asynchronous active-high reset
//   joystick1, joystick2   player words, active-high pressed, bit0 shifted out first
//   joy_load               host LOAD, active-low, asynchronous to clk
//   joy_clk                host shift clock, asynchronous to clk
//   joy_data               serial data, active-low (0 = pressed), registered
//   frame_done             one-cycle pulse once the last frame bit has been shifted past
//   link_idle              high while no LOAD has been seen for IDLE_TIMEOUT cycles
module db15_joy_responder #(
  parameter int PLAYER_BITS  = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_TIMEOUT = 4800000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PLAYER_BITS-1:0] joystick1,
  input  logic [PLAYER_BITS-1:0] joystick2,
  input  logic                   joy_load,
  input  logic                   joy_clk,
  output logic                   joy_data,
  output logic                   frame_done,
  output logic                   link_idle
);

  localparam int FRAME_BITS = 2 * PLAYER_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam int IDLE_W     = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [CNT_W-1:0]  FRAME_CNT = CNT_W'(FRAME_BITS);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOADING,
    ST_SHIFTING,
    ST_DONE
  } state_t;

  // Synchroniser chains reset to 1: LOAD inactive and the shift clock at its idle level.
  // Without that, the first cycle after reset would show a false edge.
  logic [SYNC_STAGES-1:0] load_sync_q, load_sync_d;
  logic [SYNC_STAGES-1:0] clk_sync_q,  clk_sync_d;
  logic                   load_prev_q, load_prev_d;
  logic                   clk_prev_q,  clk_prev_d;

  logic [FRAME_BITS-1:0]  sr_q,        sr_d;
  logic [CNT_W-1:0]       bit_cnt_q,   bit_cnt_d;
  logic [IDLE_W-1:0]      idle_cnt_q,  idle_cnt_d;
  logic                   joy_data_q,  joy_data_d;
  logic                   frame_done_q, frame_done_d;
  logic                   link_idle_q, link_idle_d;
  state_t                 state_q,     state_d;

  logic load_l;
  logic clk_s;
  logic clk_rise;
  logic load_fall;

  assign load_l    = load_sync_q[SYNC_STAGES-1];
  assign clk_s     = clk_sync_q[SYNC_STAGES-1];
  assign clk_rise  = clk_s & ~clk_prev_q;
  assign load_fall = ~load_l & load_prev_q;

  assign joy_data   = joy_data_q;
  assign frame_done = frame_done_q;
  assign link_idle  = link_idle_q;

  always_comb begin
    load_sync_d  = {load_sync_q[SYNC_STAGES-2:0], joy_load};
    clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], joy_clk};
    load_prev_d  = load_l;
    clk_prev_d   = clk_s;
    sr_d         = sr_q;
    bit_cnt_d    = bit_cnt_q;
    state_d      = state_q;
    frame_done_d = 1'b0;
    idle_cnt_d   = idle_cnt_q;

    if (!load_l) begin
      // LOAD dominates in every state. The register is transparent, so the
      // word present on the last low cycle is the one kept. Clock edges are
      // ignored, and a partial frame is dropped without a frame_done pulse.
      state_d   = ST_LOADING;
      sr_d      = ~{joystick2, joystick1};
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        // LOADING goes straight through to SHIFTING. An edge that arrives in
        // the same cycle that LOAD is released is still counted.
        ST_LOADING, ST_SHIFTING: begin
          state_d = ST_SHIFTING;
          if (clk_rise) begin
            sr_d      = {1'b1, sr_q[FRAME_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == FRAME_CNT - CNT_W'(1)) begin
              frame_done_d = 1'b1;
              state_d      = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          // Overrun edges shift in 1s, which reads as "not pressed", and the
          // bit count stays saturated at the frame length.
          if (clk_rise) begin
            sr_d = {1'b1, sr_q[FRAME_BITS-1:1]};
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Activity watchdog: it restarts only on a LOAD falling edge, so a LOAD
    // that is held low permanently still ends up reporting idle.
    if (load_fall) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != IDLE_MAX) begin
      idle_cnt_d = idle_cnt_q + IDLE_W'(1);
    end
    link_idle_d = (idle_cnt_d == IDLE_MAX);

    joy_data_d = sr_q[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_sync_q  <= '1;
      clk_sync_q   <= '1;
      load_prev_q  <= 1'b1;
      clk_prev_q   <= 1'b1;
      sr_q         <= '1;
      bit_cnt_q    <= '0;
      idle_cnt_q   <= IDLE_MAX;
      joy_data_q   <= 1'b1;
      frame_done_q <= 1'b0;
      link_idle_q  <= 1'b1;
      state_q      <= ST_IDLE;
    end else begin
      load_sync_q  <= load_sync_d;
      clk_sync_q   <= clk_sync_d;
      load_prev_q  <= load_prev_d;
      clk_prev_q   <= clk_prev_d;
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      joy_data_q   <= joy_data_d;
      frame_done_q <= frame_done_d;
      link_idle_q  <= link_idle_d;
      state_q      <= state_d;
    end
  end

endmodule

// File: tb/tb_db15_joy_responder.sv
module tb_db15_joy_responder;

  localparam int PB     = 16;
  localparam int HALF   = 6;
  localparam int IDLE_T = 100;

  logic          clk = 1'b0;
  logic          reset;
  logic [PB-1:0] joystick1;
  logic [PB-1:0] joystick2;
  logic          joy_load;
  logic          joy_clk;
  logic          joy_data;
  logic          frame_done;
  logic          link_idle;

  int   checks = 0;
  int   errors = 0;
  int   fd_cnt = 0;
  logic exp_q[$];

  db15_joy_responder #(
    .PLAYER_BITS (PB),
    .SYNC_STAGES (2),
    .IDLE_TIMEOUT(IDLE_T)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .joystick1 (joystick1),
    .joystick2 (joystick2),
    .joy_load  (joy_load),
    .joy_clk   (joy_clk),
    .joy_data  (joy_data),
    .frame_done(frame_done),
    .link_idle (link_idle)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected serial stream: active-low, player 1 LSB first.
  task automatic push_frame(input logic [PB-1:0] p1, input logic [PB-1:0] p2);
    logic [2*PB-1:0] w;
    w = {p2, p1};
    exp_q.delete();
    for (int i = 0; i < 2*PB; i++) exp_q.push_back(~w[i]);
  endtask

  task automatic do_load(input logic [PB-1:0] p1, input logic [PB-1:0] p2);
    joystick1 = p1;
    joystick2 = p2;
    joy_load  = 1'b0;
    wait_cyc(HALF);
    joy_load  = 1'b1;
    push_frame(p1, p2);
    wait_cyc(HALF);
  endtask

  task automatic shift_bits(input int n, input string tag, output logic [31:0] cap);
    logic e;
    cap = '0;
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = 1'b1;
      check($sformatf("%s_bit%0d", tag, i), joy_data, e);
      if (i < 32) cap[i] = joy_data;
      joy_clk = 1'b0;
      wait_cyc(HALF);
      joy_clk = 1'b1;
      wait_cyc(HALF);
    end
  endtask

  initial begin
    logic [31:0] cap;
    logic [31:0] want;
    logic [31:0] dec;
    logic        e;
    int          fd0;
    int          n;

    reset     = 1'b1;
    joy_load  = 1'b1;
    joy_clk   = 1'b1;
    joystick1 = '0;
    joystick2 = '0;
    wait_cyc(3);
    check("rst_joy_data", joy_data, 1'b1);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_link_idle", link_idle, 1'b1);
    reset = 1'b0;
    wait_cyc(2);

    // 1: a single pressed bit, then 31 released bits
    fd0 = fd_cnt;
    do_load(16'h0001, 16'h0000);
    check("t1_idle_after_load", link_idle, 1'b0);
    shift_bits(32, "t1", cap);
    wait_cyc(4);
    check("t1_frame_done_count", fd_cnt - fd0, 1);

    // 2: mixed pattern; inputs change after the load and must not leak in
    do_load(16'hA5C3, 16'h3C5A);
    joystick1 = 16'hFFFF;
    joystick2 = 16'hFFFF;
    shift_bits(32, "t2", cap);
    want = ~{16'h3C5A, 16'hA5C3};
    check("t2_word", cap, want);
    dec = ~cap;
    check("t2_loop_p1", dec[15:0], 16'hA5C3);
    check("t2_loop_p2", dec[31:16], 16'h3C5A);

    // 3: LOAD after 10 edges aborts the frame
    fd0 = fd_cnt;
    do_load(16'h1234, 16'h5678);
    shift_bits(10, "t3a", cap);
    check("t3_no_frame_done", fd_cnt - fd0, 0);
    do_load(16'h0F0F, 16'h8001);
    shift_bits(32, "t3b", cap);
    wait_cyc(4);
    want = ~{16'h8001, 16'h0F0F};
    check("t3_word", cap, want);
    check("t3_frame_done_count", fd_cnt - fd0, 1);

    // Transparent load: the word on the last low cycle wins
    joystick1 = 16'h1111;
    joystick2 = 16'h2222;
    joy_load  = 1'b0;
    wait_cyc(3);
    joystick1 = 16'h00FF;
    joystick2 = 16'hF00F;
    wait_cyc(4);
    joy_load = 1'b1;
    push_frame(16'h00FF, 16'hF00F);
    wait_cyc(HALF);
    shift_bits(32, "tlw", cap);
    want = ~{16'hF00F, 16'h00FF};
    check("tlw_word", cap, want);

    // 4: overrun edges read 1, one frame_done only
    fd0 = fd_cnt;
    do_load(16'hFFFF, 16'hFFFF);
    shift_bits(40, "t4", cap);
    wait_cyc(4);
    check("t4_frame_done_count", fd_cnt - fd0, 1);

    // 5: idle timeout, then the next LOAD clears link_idle within 4 clk
    wait_cyc(IDLE_T + 10);
    check("t5_idle_set", link_idle, 1'b1);
    joystick1 = 16'h0000;
    joystick2 = 16'h0000;
    joy_load  = 1'b0;
    n = 0;
    while (link_idle !== 1'b0 && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("t5_idle_cleared", link_idle, 1'b0);
    check("t5_clear_within_4", (n <= 4), 1'b1);
    wait_cyc(HALF);
    joy_load = 1'b1;
    exp_q.delete();
    wait_cyc(HALF);

    // 6: asynchronous reset mid-shift at bit 7
    do_load(16'h0080, 16'h0000);
    shift_bits(7, "t6", cap);
    e = exp_q.pop_front();
    check("t6_bit7_before_reset", joy_data, e);
    check("t6_idle_before_reset", link_idle, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_joy_data", joy_data, 1'b1);
    check("t6_rst_link_idle", link_idle, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    wait_cyc(2);
    shift_bits(4, "t6_noload", cap);
    fd0 = fd_cnt;
    do_load(16'hC001, 16'h0810);
    shift_bits(32, "t6_recover", cap);
    wait_cyc(4);
    want = ~{16'h0810, 16'hC001};
    check("t6_recover_word", cap, want);
    check("t6_recover_frame_done", fd_cnt - fd0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
